// File: rtl/avg_line_raster.sv
// Line-queue consumer: pops one segment, rasterizes it with integer Bresenham and
// streams clipped pixel writes to the framebuffer over a valid/ready handshake.
module avg_line_raster #(
  parameter int unsigned XRES = 640,
  parameter int unsigned YRES = 480
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        empty,
  input  logic [10:0] QStartX,
  input  logic [10:0] QStartY,
  input  logic [10:0] QEndX,
  input  logic [10:0] QEndY,
  input  logic [2:0]  QColor,
  output logic        read,
  output logic [10:0] pixX,
  output logic [10:0] pixY,
  output logic [2:0]  pixColor,
  output logic        pixValid,
  input  logic        pixReady,
  output logic        busy,
  output logic        lineDone
);

  localparam logic [11:0] XResW = 12'(XRES);
  localparam logic [11:0] YResW = 12'(YRES);

  typedef enum logic [1:0] {StIdle, StSetup, StDraw} state_e;

  state_e state_q, state_d;

  logic [10:0]        x0_q, y0_q, x1_q, y1_q;
  logic [2:0]         col_q, pix_col_q;
  logic [10:0]        dx_q, dy_q;
  logic               sx_neg_q, sy_neg_q;
  logic signed [13:0] err_q;
  logic [10:0]        cur_x_q, cur_y_q;
  logic               line_done_q;

  logic               visible, retire, at_end;
  logic [10:0]        dx_abs, dy_abs;
  logic signed [13:0] err_init, e2, dx_s, dy_s, err_step;
  logic               step_x, step_y;

  always_comb begin
    visible  = ({1'b0, cur_x_q} < XResW) && ({1'b0, cur_y_q} < YResW);
    retire   = (state_q == StDraw) && (!visible || pixReady);
    at_end   = (cur_x_q == x1_q) && (cur_y_q == y1_q);
    dx_abs   = (x1_q >= x0_q) ? (x1_q - x0_q) : (x0_q - x1_q);
    dy_abs   = (y1_q >= y0_q) ? (y1_q - y0_q) : (y0_q - y1_q);
    err_init = $signed({3'b000, dx_abs}) - $signed({3'b000, dy_abs});
    // Both step tests use the pre-step error term.
    e2       = {err_q[12:0], 1'b0};
    dx_s     = $signed({3'b000, dx_q});
    dy_s     = 14'sd0 - $signed({3'b000, dy_q});
    step_x   = (e2 >= dy_s);
    step_y   = (e2 <= dx_s);
    err_step = err_q + (step_x ? dy_s : 14'sd0) + (step_y ? dx_s : 14'sd0);
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (!empty) state_d = StSetup;
      StSetup: state_d = StDraw;
      StDraw:  if (retire && at_end) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    // Gated by reset so queued entries survive a reset untouched.
    read     = (state_q == StIdle) && !empty && rst_b;
    busy     = (state_q != StIdle);
    pixValid = (state_q == StDraw) && visible;
    pixX     = cur_x_q;
    pixY     = cur_y_q;
    pixColor = pix_col_q;
    lineDone = line_done_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      x0_q        <= '0;
      y0_q        <= '0;
      x1_q        <= '0;
      y1_q        <= '0;
      col_q       <= '0;
      pix_col_q   <= '0;
      dx_q        <= '0;
      dy_q        <= '0;
      sx_neg_q    <= 1'b0;
      sy_neg_q    <= 1'b0;
      err_q       <= '0;
      cur_x_q     <= '0;
      cur_y_q     <= '0;
      line_done_q <= 1'b0;
    end else begin
      line_done_q <= retire && at_end;
      if (state_q == StIdle && !empty) begin
        x0_q  <= QStartX;
        y0_q  <= QStartY;
        x1_q  <= QEndX;
        y1_q  <= QEndY;
        col_q <= QColor;
      end
      if (state_q == StSetup) begin
        dx_q      <= dx_abs;
        dy_q      <= dy_abs;
        sx_neg_q  <= !(x0_q < x1_q);
        sy_neg_q  <= !(y0_q < y1_q);
        err_q     <= err_init;
        cur_x_q   <= x0_q;
        cur_y_q   <= y0_q;
        pix_col_q <= col_q;
      end
      if (retire && !at_end) begin
        if (step_x) cur_x_q <= sx_neg_q ? (cur_x_q - 11'd1) : (cur_x_q + 11'd1);
        if (step_y) cur_y_q <= sy_neg_q ? (cur_y_q - 11'd1) : (cur_y_q + 11'd1);
        err_q <= err_step;
      end
    end
  end

endmodule

// File: tb/tb_avg_line_raster.sv
// Directed bench for avg_line_raster: queue model feeds segments, a scoreboard of
// expected pixels is filled when a segment is queued and drained on each accepted pixel.
module tb_avg_line_raster;

  typedef struct {
    int x0;
    int y0;
    int x1;
    int y1;
    int c;
  } seg_t;

  logic        clk;
  logic        rst_b;
  logic        empty;
  logic [10:0] QStartX, QStartY, QEndX, QEndY;
  logic [2:0]  QColor;
  logic        read;
  logic [10:0] pixX, pixY;
  logic [2:0]  pixColor;
  logic        pixValid;
  logic        pixReady;
  logic        busy;
  logic        lineDone;

  seg_t        seg_q[$];
  logic [24:0] exp_q[$];
  logic [24:0] exp_px;

  int n_cmp = 0;
  int n_bad = 0;
  int pop_cnt = 0;
  int r_reads, r_read_cyc, r_first, r_done, r_busy, r_read_at_done, r_stall_seen;
  int reads_seen;
  int found;

  avg_line_raster #(
    .XRES(640),
    .YRES(480)
  ) dut (
    .clk      (clk),
    .rst_b    (rst_b),
    .empty    (empty),
    .QStartX  (QStartX),
    .QStartY  (QStartY),
    .QEndX    (QEndX),
    .QEndY    (QEndY),
    .QColor   (QColor),
    .read     (read),
    .pixX     (pixX),
    .pixY     (pixY),
    .pixColor (pixColor),
    .pixValid (pixValid),
    .pixReady (pixReady),
    .busy     (busy),
    .lineDone (lineDone)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic drive_head();
    empty = (seg_q.size() == 0);
    if (seg_q.size() != 0) begin
      QStartX = 11'(seg_q[0].x0);
      QStartY = 11'(seg_q[0].y0);
      QEndX   = 11'(seg_q[0].x1);
      QEndY   = 11'(seg_q[0].y1);
      QColor  = 3'(seg_q[0].c);
    end
  endtask

  task automatic push_seg(input int x0, input int y0, input int x1, input int y1, input int c);
    seg_t s;
    s.x0 = x0;
    s.y0 = y0;
    s.x1 = x1;
    s.y1 = y1;
    s.c  = c;
    seg_q.push_back(s);
    drive_head();
  endtask

  task automatic exp_pix(input int x, input int y, input int c);
    exp_q.push_back({11'(x), 11'(y), 3'(c)});
  endtask

  // Queue model: head advances on the edge where read && !empty.
  always @(posedge clk) begin
    if (read && !empty) begin
      seg_q.delete(0);
      pop_cnt++;
    end
    #1 drive_head();
  end

  // Scoreboard drain on every accepted pixel.
  always @(negedge clk) begin
    if (pixValid && pixReady) begin
      check("pix_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        exp_px = exp_q.pop_front();
        check("pix_xyc", {7'b0, pixX, pixY, pixColor}, {7'b0, exp_px});
      end
    end
  end

  // Runs until lineDone (bounded), optionally stalling pixReady on one coordinate.
  task automatic run_seg(input int st_x, input int st_y, input int st_n);
    int stalls = 0;
    r_reads = 0;
    r_read_cyc = -1;
    r_first = -1;
    r_done = -1;
    r_busy = 0;
    r_read_at_done = 0;
    r_stall_seen = 0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      if (pixValid && int'(pixX) == st_x && int'(pixY) == st_y && stalls < st_n) begin
        pixReady = 1'b0;
        stalls++;
      end else begin
        pixReady = 1'b1;
      end
      @(negedge clk);
      if (read) begin
        r_reads++;
        if (r_read_cyc < 0) r_read_cyc = cyc;
      end
      if (pixValid && r_first < 0) r_first = cyc;
      if (busy) r_busy++;
      if (pixValid && int'(pixX) == st_x && int'(pixY) == st_y) r_stall_seen++;
      if (lineDone) begin
        r_done = cyc;
        r_read_at_done = int'(read);
        break;
      end
      @(posedge clk);
      #1;
    end
    pixReady = 1'b1;
    check("line_done_seen", 32'(r_done >= 0), 32'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_b = 1'b0;
    pixReady = 1'b1;
    QStartX = '0;
    QStartY = '0;
    QEndX = '0;
    QEndY = '0;
    QColor = '0;
    drive_head();
    repeat (3) @(posedge clk);
    #1 rst_b = 1'b1;

    @(negedge clk);
    check("rst_read", 32'(read), 32'd0);
    check("rst_pixValid", 32'(pixValid), 32'd0);
    check("rst_pixX", 32'(pixX), 32'd0);
    check("rst_pixY", 32'(pixY), 32'd0);
    check("rst_pixColor", 32'(pixColor), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_lineDone", 32'(lineDone), 32'd0);
    @(posedge clk);
    #1;

    // Horizontal segment
    push_seg(10, 5, 13, 5, 3);
    for (int i = 10; i <= 13; i++) exp_pix(i, 5, 3);
    run_seg(-1, -1, 0);
    check("horiz_reads", r_reads, 1);
    check("horiz_latency", r_first - r_read_cyc, 2);
    check("horiz_done_cycle", r_done - r_read_cyc, 6);
    check("horiz_busy", r_busy, 5);
    check("horiz_drained", exp_q.size(), 0);

    // Steep segment, both directions
    push_seg(0, 0, 1, 3, 1);
    exp_pix(0, 0, 1);
    exp_pix(0, 1, 1);
    exp_pix(1, 2, 1);
    exp_pix(1, 3, 1);
    run_seg(-1, -1, 0);
    check("steep_busy", r_busy, 5);
    check("steep_drained", exp_q.size(), 0);
    push_seg(1, 3, 0, 0, 4);
    exp_pix(1, 3, 4);
    exp_pix(1, 2, 4);
    exp_pix(0, 1, 4);
    exp_pix(0, 0, 4);
    run_seg(-1, -1, 0);
    check("steep_rev_busy", r_busy, 5);
    check("steep_rev_drained", exp_q.size(), 0);

    // Backpressure on (3,3)
    push_seg(2, 2, 5, 5, 2);
    for (int i = 2; i <= 5; i++) exp_pix(i, i, 2);
    run_seg(3, 3, 3);
    check("bp_held_cycles", r_stall_seen, 4);
    check("bp_busy", r_busy, 8);
    check("bp_done_cycle", r_done - r_read_cyc, 9);
    check("bp_drained", exp_q.size(), 0);

    // Clipping at XRES
    push_seg(638, 0, 641, 0, 5);
    exp_pix(638, 0, 5);
    exp_pix(639, 0, 5);
    run_seg(-1, -1, 0);
    check("clip_busy", r_busy, 5);
    check("clip_done_cycle", r_done - r_read_cyc, 6);
    check("clip_drained", exp_q.size(), 0);

    // Queue interaction
    reads_seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (read) reads_seen++;
    end
    check("empty_no_read", reads_seen, 0);
    @(posedge clk);
    #1;
    pop_cnt = 0;
    push_seg(20, 20, 21, 20, 6);
    exp_pix(20, 20, 6);
    exp_pix(21, 20, 6);
    push_seg(7, 7, 7, 7, 7);
    exp_pix(7, 7, 7);
    run_seg(-1, -1, 0);
    check("q_read_at_done", r_read_at_done, 1);
    check("q_first_reads", r_reads, 2);
    run_seg(-1, -1, 0);
    check("q_degen_reads", r_reads, 0);
    check("q_degen_busy", r_busy, 2);
    check("q_degen_done", r_done, 2);
    check("q_pops", pop_cnt, 2);
    check("q_drained", exp_q.size(), 0);

    // Reset mid-segment
    pop_cnt = 0;
    push_seg(0, 0, 100, 0, 3);
    for (int i = 0; i <= 100; i++) exp_pix(i, 0, 3);
    found = 0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      if (pixValid && pixX == 11'd40) begin
        found = 1;
        break;
      end
      @(posedge clk);
      #1;
    end
    check("rst_mid_reached_40", found, 1);
    rst_b = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #1;
    exp_q.delete();
    check("rst_mid_pixValid", 32'(pixValid), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_pixX", 32'(pixX), 32'd0);
    check("rst_mid_pixY", 32'(pixY), 32'd0);
    check("rst_mid_pixColor", 32'(pixColor), 32'd0);
    push_seg(4, 4, 6, 4, 5);
    for (int i = 4; i <= 6; i++) exp_pix(i, 4, 5);
    @(negedge clk);
    check("rst_mid_no_read_in_reset", 32'(read), 32'd0);
    @(posedge clk);
    #1 rst_b = 1'b1;
    check("rst_mid_pops_before", pop_cnt, 1);
    run_seg(-1, -1, 0);
    check("rst_mid_reads", r_reads, 1);
    check("rst_mid_latency", r_first - r_read_cyc, 2);
    check("rst_mid_pops_after", pop_cnt, 2);
    check("rst_mid_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
